// File: rtl/flatten_pkg.sv
// Shared types and defaults for the flatten stage read scheduler.
package flatten_pkg;

  localparam int NCH_DEF          = 16;
  localparam int OUT_PER_IN_DEF   = 16;
  localparam int PIX_W_DEF        = 10;
  localparam int MAX_INFLIGHT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter width that stays legal for degenerate (<= 1) ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flatten_inflight_tracker.sv
// Tracks reads issued but not yet fully emitted by the line buffer, and flags
// line-buffer strobes that arrive with nothing outstanding.
module flatten_inflight_tracker
  import flatten_pkg::*;
#(
  parameter int OUT_PER_IN   = OUT_PER_IN_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int SW           = cnt_w(OUT_PER_IN),
  parameter int IW           = cnt_w(MAX_INFLIGHT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic rd,
  input  logic lb_valid_out,
  output logic room,
  output logic drained,
  output logic err
);

  localparam logic [SW-1:0] SUB_LAST = SW'(OUT_PER_IN - 1);
  localparam logic [IW-1:0] INF_MAX  = IW'(MAX_INFLIGHT);

  logic [IW-1:0] inflight;
  logic [SW-1:0] sub_cnt;
  logic          spurious, adv, wrap;

  // A strobe with nothing outstanding is dropped so the count never underflows.
  assign spurious = lb_valid_out && (inflight == '0) && (sub_cnt == '0);
  assign adv      = lb_valid_out && !spurious;
  assign wrap     = adv && (sub_cnt == SUB_LAST);
  assign room     = inflight < INF_MAX;
  assign drained  = (inflight == '0) && (sub_cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      sub_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      if (spurious) err <= 1'b1;
      if (clr) begin
        inflight <= '0;
        sub_cnt  <= '0;
      end else begin
        if (adv) sub_cnt <= wrap ? '0 : sub_cnt + 1'b1;
        case ({rd, wrap})
          2'b10:   inflight <= inflight + 1'b1;
          2'b01:   inflight <= inflight - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/flatten_read_scheduler.sv
// Frame-level read scheduler: gates the shared channel-FIFO read strobe against
// input availability, output space and line-buffer depth, then drains and reports.
module flatten_read_scheduler
  import flatten_pkg::*;
#(
  parameter int NCH          = NCH_DEF,
  parameter int OUT_PER_IN   = OUT_PER_IN_DEF,
  parameter int PIX_W        = PIX_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PIX_W-1:0] frame_pixels,
  input  logic [NCH-1:0]   ff_empty,
  input  logic             ff_almost_full,
  input  logic             ff_full,
  input  logic             lb_valid_out,
  output logic             ff_rdreq,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [PIX_W-1:0] rd_count
);

  state_t           state, state_nx;
  logic [PIX_W-1:0] len_q;
  logic             room, drained, fifo_ok, accept;

  assign fifo_ok = ~|ff_empty && !ff_almost_full && !ff_full;
  assign accept  = (state == IDLE) && start;

  // Combinational so a FIFO holding a single word is never read twice.
  assign ff_rdreq = (state == RUN) && !abort && fifo_ok && (rd_count < len_q) && room;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (frame_pixels != '0) ? RUN : DONE;
      RUN:   if (abort || (rd_count == len_q)) state_nx = DRAIN;
      DRAIN: if (drained) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      rd_count <= '0;
      aborted  <= 1'b0;
    end else begin
      if (accept) begin
        len_q    <= frame_pixels;
        rd_count <= '0;
        aborted  <= 1'b0;
      end else if (ff_rdreq) begin
        rd_count <= rd_count + 1'b1;
      end
      if ((state == RUN) && abort) aborted <= 1'b1;
    end
  end

  flatten_inflight_tracker #(
    .OUT_PER_IN   (OUT_PER_IN),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_track (
    .clock        (clock),
    .reset        (reset),
    .clr          (accept),
    .rd           (ff_rdreq),
    .lb_valid_out (lb_valid_out),
    .room         (room),
    .drained      (drained),
    .err          (err)
  );

endmodule

// File: tb/tb_flatten_read_scheduler.sv
// Directed bench for flatten_read_scheduler with a line-buffer model and
// scoreboard queues for read indices and done timing.
module tb_flatten_read_scheduler;

  localparam int NCH  = 16;
  localparam int OPI  = 16;
  localparam int PW   = 10;
  localparam int MAXI = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [PW-1:0]  frame_pixels = '0;
  logic [NCH-1:0] ff_empty = '0;
  logic           ff_almost_full = 1'b0;
  logic           ff_full = 1'b0;
  logic           lb_valid_out = 1'b0;
  logic           ff_rdreq, busy, done, aborted, err;
  logic [PW-1:0]  rd_count;

  flatten_read_scheduler #(
    .NCH(NCH), .OUT_PER_IN(OPI), .PIX_W(PW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .frame_pixels   (frame_pixels),
    .ff_empty       (ff_empty),
    .ff_almost_full (ff_almost_full),
    .ff_full        (ff_full),
    .lb_valid_out   (lb_valid_out),
    .ff_rdreq       (ff_rdreq),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .err            (err),
    .rd_count       (rd_count)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  int rd_q[$], done_q[$], lb_ready[$], rd_hist[$];
  int lb_sub = 0, tb_inflight = 0, frame_words = 0, first_wrap = -1, sc = 0;
  bit lb_stall = 1'b0, lb_force = 1'b0, done_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, advance the line-buffer model after posedge.
  task automatic step();
    int inf0;
    @(negedge clock);
    inf0 = tb_inflight;
    if ((|ff_empty) || ff_almost_full || ff_full || abort || inf0 >= MAXI)
      chk("rd_gate", ff_rdreq, 0);
    if (ff_rdreq === 1'b1) begin
      rd_hist.push_back(cyc);
      chk("rd_pending", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) chk("rd_idx", rd_count, rd_q.pop_front());
      lb_ready.push_back(cyc + 3);
      tb_inflight++;
    end
    if (lb_valid_out === 1'b1 && !lb_force) begin
      frame_words++;
      lb_sub++;
      if (lb_sub == OPI) begin
        lb_sub = 0;
        void'(lb_ready.pop_front());
        tb_inflight--;
        if (first_wrap < 0) first_wrap = cyc;
        if (tb_inflight == 0 && rd_q.size() == 0) done_q.push_back(cyc + 2);
      end
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      chk("busy_in_done", busy, 0);
      chk("done_expected", done_q.size() != 0, 1);
      if (done_q.size() != 0) chk("done_cyc", cyc, done_q.pop_front());
    end
    @(posedge clock);
    #1;
    cyc++;
    if (!lb_force)
      lb_valid_out = !lb_stall && lb_ready.size() > 0 && lb_ready[0] <= cyc;
  endtask

  task automatic start_frame(input int n);
    done_seen   = 1'b0;
    frame_words = 0;
    first_wrap  = -1;
    rd_hist.delete();
    for (int i = 0; i < n; i++) rd_q.push_back(i);
    if (n == 0) done_q.push_back(cyc + 1);
    frame_pixels = PW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start", busy, n != 0);
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) step();
    chk("done_seen", done_seen, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdreq"}, ff_rdreq, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_count"}, rd_count, 0);
  endtask

  initial begin
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Nominal 4-pixel frame
    sc = cyc;
    start_frame(4);
    run_until_done(200);
    chk("nom_rd_count", rd_count, 4);
    chk("nom_reads", rd_hist.size(), 4);
    chk("nom_first_lat", rd_hist[0], sc + 1);
    chk("nom_b2b", rd_hist[3] - rd_hist[0], 3);
    chk("nom_words", frame_words, 64);
    chk("nom_busy_after", busy, 0);

    // Starvation on channel 7 after the first read
    start_frame(4);
    step();
    ff_empty[7] = 1'b1;
    repeat (5) step();
    ff_empty[7] = 1'b0;
    run_until_done(200);
    chk("starve_rd_count", rd_count, 4);
    chk("starve_reads", rd_hist.size(), 4);
    chk("starve_gap", rd_hist[1] - rd_hist[0], 6);

    // Backpressure: inflight cap, single-read release per wrap, almost-full
    lb_stall = 1'b1;
    start_frame(8);
    repeat (12) step();
    chk("bp_cap", rd_hist.size(), 4);
    lb_stall = 1'b0;
    for (int i = 0; i < 60 && rd_hist.size() < 5; i++) step();
    lb_stall = 1'b1;
    chk("bp_release", rd_hist[4], first_wrap + 1);
    repeat (20) step();
    chk("bp_one_per_wrap", rd_hist.size(), 5);
    ff_almost_full = 1'b1;
    lb_stall = 1'b0;
    repeat (40) step();
    chk("af_block", rd_hist.size(), 5);
    ff_almost_full = 1'b0;
    run_until_done(400);
    chk("bp_rd_count", rd_count, 8);
    chk("bp_words", frame_words, 128);

    // Zero-length frame
    start_frame(0);
    run_until_done(10);
    chk("zero_reads", rd_hist.size(), 0);
    chk("zero_rd_count", rd_count, 0);

    // Abort after two reads of a full 28x28 frame
    start_frame(784);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    rd_q.delete();
    chk("abort_reads", rd_hist.size(), 2);
    chk("abort_sticky_drain", aborted, 1);
    run_until_done(200);
    chk("abort_words", frame_words, 32);
    chk("abort_sticky_end", aborted, 1);
    chk("abort_rd_count", rd_count, 2);

    // Spurious line-buffer strobe in IDLE
    lb_force = 1'b1;
    lb_valid_out = 1'b1;
    step();
    lb_valid_out = 1'b0;
    step();
    lb_force = 1'b0;
    chk("err_set", err, 1);

    // Next start clears aborted; reset mid-RUN is immediate
    start_frame(784);
    chk("aborted_cleared", aborted, 0);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rd_q.delete();
    lb_ready.delete();
    done_q.delete();
    tb_inflight = 0;
    lb_sub = 0;
    lb_valid_out = 1'b0;
    step();
    reset = 1'b1;
    step();
    start_frame(3);
    run_until_done(200);
    chk("post_rst_rd_count", rd_count, 3);
    chk("post_rst_words", frame_words, 48);
    chk("post_rst_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flatten_read_scheduler.md
Name: flatten_read_scheduler

Overview:
- Frame-level controller for the 16-channel flatten stage.
- Owns the read request to the 16 per-channel input FIFOs. Issues exactly one read per pixel position until a programmed frame length is consumed.
- Throttles reads against output-FIFO space and line-buffer in-flight depth, then drains the flatten pipeline and signals completion.
- Sits between the conv/pool channel FIFOs and the dense-layer input FIFO.

Parameters:
- NCH, 16, number of channel FIFOs gated together.
- OUT_PER_IN, 16, output words the flatten line buffer emits per read.
- PIX_W, 10, width of frame pixel count (28*28 = 784 fits).
- MAX_INFLIGHT, 4, maximum reads issued but not yet fully emitted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- abort  in  1  synchronous stop request; stops issuing reads.
- frame_pixels  in  PIX_W  reads per frame; latched on accepted start.
- ff_empty  in  NCH  per-channel input FIFO empty flags (show-ahead FIFOs).
- ff_almost_full  in  1  output FIFO almost-full.
- ff_full  in  1  output FIFO full.
- lb_valid_out  in  1  line-buffer output strobe (same signal as the output FIFO write request).
- ff_rdreq  out  1  read strobe to all NCH channel FIFOs and the line-buffer valid input.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the frame is fully emitted.
- aborted  out  1  sticky; set when a frame ended by abort, cleared on next accepted start.
- err  out  1  sticky; lb_valid_out seen with nothing in flight. Cleared only by reset.
- rd_count  out  PIX_W  reads issued in the current frame.

Behaviour:
- Reset (reset = 0): state IDLE, all counters 0, ff_rdreq/busy/done/aborted/err = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with frame_pixels > 0 -> RUN; latch length; clear rd_count, inflight, sub-counter and aborted.
  - start with frame_pixels = 0 -> DONE directly.
- RUN:
  - ff_rdreq is combinational and equals: state == RUN, no abort, all ff_empty = 0, ff_almost_full = 0, ff_full = 0, rd_count < latched length, inflight < MAX_INFLIGHT.
  - Combinational rdreq is required so back-to-back reads never underflow a FIFO holding one word.
  - Max one read per cycle; zero-bubble back-to-back reads while all conditions hold.
- Per read: rd_count += 1 and inflight += 1 on each cycle ff_rdreq = 1.
- Output tracking:
  - Sub-counter (0..OUT_PER_IN-1) advances on lb_valid_out.
  - On wrap, inflight -= 1.
  - A read and a wrap in the same cycle leave inflight unchanged.
- RUN -> DRAIN when rd_count reaches the latched length (the cycle after the last read), or when abort = 1.
  - abort sets aborted.
  - No reads are issued in the abort cycle or after it.
- DRAIN: no reads. When inflight = 0 and sub-counter = 0 -> DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. busy = 0 in DONE.
- start in RUN/DRAIN/DONE is ignored. abort in IDLE/DRAIN/DONE is ignored.
- err: lb_valid_out while inflight = 0 and sub-counter = 0 sets err. The count is not decremented below 0.
- Latency:
  - start to first ff_rdreq: 1 cycle, if FIFOs are ready.
  - Last emitted word to done: 2 cycles (DRAIN detect, DONE).
- Asynchronous reset mid-frame returns to IDLE immediately; in-flight outputs are not tracked afterward.

Decomposition:
- Shared package (flatten_pkg) holds:
  - state encoding constants: IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3;
  - default NCH, OUT_PER_IN, PIX_W.
- One sub-module, flatten_inflight_tracker: sub-counter plus inflight up/down counter with the err detect. The scheduler FSM stays in the top.

Test Plan:
- Nominal frame: frame_pixels = 4, FIFOs never empty, line-buffer model emits 16 words per read after 3 cycles -> 4 consecutive ff_rdreq cycles, rd_count = 4, done 2 cycles after the 64th lb_valid_out, busy then low.
- Starvation: ff_empty[7] = 1 during read 2 for 5 cycles -> ff_rdreq = 0 in those cycles, no FIFO underflow, frame still ends with rd_count = 4.
- Backpressure: MAX_INFLIGHT = 4, line buffer stalled -> reads stop at 4; each 16-word wrap releases exactly one read. ff_almost_full = 1 blocks reads in the same cycle.
- Zero length: start with frame_pixels = 0 -> done one cycle after start, ff_rdreq never asserted.
- Abort: abort after 2 of 784 reads -> no further ff_rdreq, done after 32 output words drain, aborted = 1; next start clears aborted.
- Error and reset: lb_valid_out pulse in IDLE -> err = 1. Reset low mid-RUN -> all outputs 0 asynchronously; a subsequent start of 3 pixels completes normally.
